// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// ----------------
// Scans a 4x3 matrix keypad one row at a time. It synchronizes the column
// returns, assembles a 12-bit snapshot once per frame (four row dwells), and
// debounces whole frames. Each accepted press is emitted once as a one-hot
// key code with a single-cycle strobe.
//
// Parameters
//   SCAN_DIV  clk cycles each row is driven (4..65535)
//   DEB_CNT   identical frames needed to accept a press / confirm a release (1..15)
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   col_in     keypad columns, active-low, asynchronous to clk
//   row_out    row drive, active-low, exactly one bit low
//   key_data   one-hot accepted key: bits 0-9 digits, bit 10 '*', bit 11 '#'
//   key_valid  one-cycle pulse when key_data is updated
//   key_down   high until the accepted key is confirmed released
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  col_in,
  output logic [3:0]  row_out,
  output logic [11:0] key_data,
  output logic        key_valid,
  output logic        key_down
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [4:0]  DEB_TARGET = 5'(DEB_CNT);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  // Two-flop column synchronizer; resets to "no key pressed".
  logic [2:0] sync_a_reg;
  logic [2:0] sync_b_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a_reg <= 3'b111;
      sync_b_reg <= 3'b111;
    end else begin
      sync_a_reg <= col_in;
      sync_b_reg <= sync_a_reg;
    end
  end

  // Row scanning. The last dwell cycle samples the current row, and the
  // row drive then moves on, so row_out changes on the cycle after a sample.
  logic [15:0] dwell_reg;
  logic [1:0]  row_idx_reg;
  logic [8:0]  raw_reg;      // rows 0..2. Row 3 is used directly at frame end.
  logic        sample;
  logic        frame_end;

  assign sample    = (dwell_reg == DWELL_LAST);
  assign frame_end = sample && (row_idx_reg == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_reg   <= '0;
      row_idx_reg <= 2'd0;
      row_out     <= 4'b1110;
      raw_reg     <= '0;
    end else if (sample) begin
      dwell_reg   <= '0;
      row_idx_reg <= row_idx_reg + 2'd1;
      row_out     <= {row_out[2:0], row_out[3]};
      case (row_idx_reg)
        2'd0:    raw_reg[2:0] <= ~sync_b_reg;
        2'd1:    raw_reg[5:3] <= ~sync_b_reg;
        2'd2:    raw_reg[8:6] <= ~sync_b_reg;
        default: ;
      endcase
    end else begin
      dwell_reg <= dwell_reg + 16'd1;
    end
  end

  // The full frame snapshot is indexed row*3+col. It is remapped onto key-code bits:
  // raw 0..8 are digits 1..9, raw 9 is '*', raw 10 is '0', raw 11 is '#'.
  logic [11:0] snapshot;
  logic [11:0] frame_code;
  logic        frame_is_key;

  assign snapshot = {~sync_b_reg, raw_reg};

  for (genvar gi = 0; gi < 12; gi++) begin : g_keymap
    localparam int SRC = (gi == 0)  ? 10 :
                         (gi <= 9)  ? gi - 1 :
                         (gi == 10) ? 9 : 11;
    assign frame_code[gi] = snapshot[SRC];
  end

  // Only a frame with exactly one key counts. Chords and ghosts read as empty.
  assign frame_is_key = (frame_code != 12'd0) &&
                        ((frame_code & (frame_code - 12'd1)) == 12'd0);

  // Debounce FSM. It only advances at frame end.
  state_t      state_reg, state_next;
  logic [11:0] cand_reg, cand_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [4:0]  cnt_inc;
  logic [11:0] key_data_next;
  logic        key_valid_next;
  logic        key_down_next;

  assign cnt_inc = {1'b0, cnt_reg} + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cand_reg  <= '0;
      cnt_reg   <= '0;
      key_data  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      key_data  <= key_data_next;
      key_valid <= key_valid_next;
      key_down  <= key_down_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    key_data_next  = key_data;
    key_valid_next = 1'b0;
    key_down_next  = key_down;

    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (frame_is_key) begin
            cand_next = frame_code;
            if (DEB_CNT == 1) begin
              key_data_next  = frame_code;
              key_valid_next = 1'b1;
              key_down_next  = 1'b1;
              cnt_next       = '0;
              state_next     = HELD;
            end else begin
              cnt_next   = 4'd1;
              state_next = DEBOUNCE;
            end
          end
        end

        DEBOUNCE: begin
          if (!frame_is_key) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else if (frame_code != cand_reg) begin
            // A different key restarts the count with the new candidate.
            cand_next = frame_code;
            cnt_next  = 4'd1;
          end else if (cnt_inc == DEB_TARGET) begin
            key_data_next  = cand_reg;
            key_valid_next = 1'b1;
            key_down_next  = 1'b1;
            cnt_next       = '0;
            state_next     = HELD;
          end else begin
            cnt_next = cnt_inc[3:0];
          end
        end

        HELD: begin
          // Any key frame, including a different key, restarts the release
          // count. This prevents auto-repeat and roll-over emission.
          if (frame_is_key) begin
            cnt_next = '0;
          end else if (cnt_inc == DEB_TARGET) begin
            cnt_next      = '0;
            key_down_next = 1'b0;
            state_next    = IDLE;
          end else begin
            cnt_next = cnt_inc[3:0];
          end
        end

        default: begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x3 matrix keypad feeding the eight-digit keypad display. It drives keypad rows round-robin, samples and synchronizes the column lines, and debounces whole-frame snapshots. Each accepted press is emitted exactly once as a one-hot 12-bit key code with a single-cycle strobe. That code and strobe are what the display block consumes as its scan data and valid inputs.

## Interface
- SCAN_DIV, default 1000: clk cycles each row is driven (dwell); legal range 4..65535
- DEB_CNT, default 4: consecutive identical frames required to accept a press or confirm a release; legal range 1..15
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low. Clock is clk.
- col_in  in  3  keypad columns, active-low, asynchronous to clk
- row_out  out  4  keypad row drive, active-low, exactly one bit low at all times
- key_data  out  12  one-hot accepted key: bits 0-9 = digits 0-9, bit 10 = '*', bit 11 = '#'
- key_valid  out  1  one-cycle pulse when key_data is updated
- key_down  out  1  high while an accepted key has not yet been confirmed released

## Operation
- Key map (row, col -> bit): row0: 1,2,3; row1: 4,5,6; row2: 7,8,9; row3: '*',0,'#'.
- col_in passes through a 2-flop synchronizer before use.
- Dwell counter runs 0..SCAN_DIV-1. At count SCAN_DIV-1:
  - Sample the synchronized, inverted columns into the 3 raw bits of the current row.
  - Rotate row_out (row0->row1->row2->row3->row0).
- A frame is 4 dwells starting at row0. The row3 sample completes the 12-bit raw snapshot ("frame end").
- Frame classification: zero bits = EMPTY; exactly one bit = KEY(code); two or more bits = EMPTY (ghost/chord rejected).
- FSM is evaluated only at frame end. States and transitions:
  - IDLE:
    - KEY(c) -> cand=c, cnt=1. If DEB_CNT==1, accept immediately; else go to DEBOUNCE.
    - EMPTY -> stay in IDLE.
  - DEBOUNCE:
    - KEY(c), c==cand -> cnt+1. When cnt reaches DEB_CNT, accept.
    - KEY(c), c!=cand -> cand=c, cnt=1, stay in DEBOUNCE.
    - EMPTY -> IDLE.
  - Accept: key_data<=cand, key_valid pulses, key_down<=1, go to HELD, cnt=0.
  - HELD:
    - EMPTY -> cnt+1. At DEB_CNT, go to IDLE with key_down<=0.
    - Any KEY -> cnt=0. No new emission, even for a different key.
- key_data holds its value until the next accept. Releasing a key does not clear it.
- Holding a key never produces auto-repeat. A new press requires a confirmed release first.

## Timing
- Reset values:
  - row_out=4'b1110
  - key_data=0, key_valid=0, key_down=0
  - dwell counter=0, FSM=IDLE, cand=0, cnt=0
  - synchronizer flops=3'b111 (not pressed)
- Reset asserted mid-operation aborts any debounce. Scanning restarts at row0 on the first clk edge after release.
- Frame length is exactly 4*SCAN_DIV cycles. row_out changes only on the cycle after a sample.
- Column settle plus synchronizer: col_in must be stable ≥3 cycles before the sample cycle. This is guaranteed because SCAN_DIV ≥ 4.
- Accept latency: key_valid is high for the single clk cycle after the frame end of the DEB_CNT-th consecutive matching frame. key_data and key_down update in that same cycle.
- A key that is pressed mid-frame, and therefore missed by the current row, is counted from the first frame that samples it.
- The release-confirm frame end and a new press cannot coincide. A release needs DEB_CNT EMPTY frames; only then does IDLE start counting a new key.

## Test plan
- Reset: hold rst=0 with random col_in -> row_out=1110, key_data=0, key_valid=0, key_down=0. After release, row_out steps 1110->1101->1011->0111->1110 every SCAN_DIV cycles.
- Single press, SCAN_DIV=4, DEB_CNT=3: press '5' (row1,col1) for 10 frames, then release -> exactly one key_valid pulse, with key_data=12'h020 at the cycle after the 3rd full frame end. key_down falls after 3 empty frames. key_data stays 12'h020.
- Bounce: '#' toggles present/absent every frame for 6 frames, then is stable -> no pulse during the toggling. Exactly one pulse with key_data=12'h800 after 3 stable frames.
- Chord/change: '1' and '2' pressed together -> no pulse. Candidate '7' for 2 frames then '8' -> the count restarts, and only '8' (12'h100) is accepted after 3 more frames.
- Hold/no-repeat: hold '0' for 50 frames -> exactly one pulse, key_data=12'h001. Switch to '9' without release -> no pulse. Release 3 frames, then press '9' -> one pulse, key_data=12'h200.
- Reset mid-debounce: assert rst after 2 matching frames of '*' -> outputs return to reset values. After deassertion, '*' still held -> pulse with 12'h400 only after 3 new full frames.
